// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and shared-alu bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [WIDTH-1:0]  rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [CTRL_W-1:0] req1_ctrl;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [WIDTH-1:0]  rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational alu between two requesters
module alu_arbiter #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  logic [1:0]            req_valid;
  logic [1:0]            rsp_ready;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  supported;
  logic [WIDTH-1:0]      alu_a_mux;
  logic [WIDTH-1:0]      alu_b_mux;
  logic [CTRL_W-1:0]     alu_ctrl_mux;

  logic                  last_grant_q, last_grant_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_zero_q, rsp_zero_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [1:0][WIDTH-1:0] rsp_result_q, rsp_result_d;

  function automatic logic is_supported(input logic [CTRL_W-1:0] c);
    case (c)
      CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010),
      CTRL_W'(4'b0110), CTRL_W'(4'b0111), CTRL_W'(4'b1100): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    req_valid = {bus.req1_valid, bus.req0_valid};
    rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    for (int i = 0; i < 2; i++) begin
      // A slot is free when empty or being drained this very cycle.
      elig[i] = !reset && req_valid[i] && (!rsp_valid_q[i] || rsp_ready[i]);
    end
    grant[0] = elig[0] && (!elig[1] || last_grant_q);
    grant[1] = elig[1] && (!elig[0] || !last_grant_q);

    alu_a_mux    = '0;
    alu_b_mux    = '0;
    alu_ctrl_mux = '0;
    if (grant[0]) begin
      alu_a_mux    = bus.req0_a;
      alu_b_mux    = bus.req0_b;
      alu_ctrl_mux = bus.req0_ctrl;
    end else if (grant[1]) begin
      alu_a_mux    = bus.req1_a;
      alu_b_mux    = bus.req1_b;
      alu_ctrl_mux = bus.req1_ctrl;
    end
    supported = is_supported(alu_ctrl_mux);

    last_grant_d = last_grant_q;
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end

    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i] && !rsp_ready[i];
      if (grant[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = supported ? bus.alu_result : '0;
        rsp_zero_d[i]   = supported ? bus.alu_zero : 1'b1;
        rsp_err_d[i]    = !supported;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.alu_a       = alu_a_mux;
  assign bus.alu_b       = alu_b_mux;
  assign bus.alu_ctrl    = alu_ctrl_mux;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp0_zero   = rsp_zero_q[0];
  assign bus.rsp0_err    = rsp_err_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp1_zero   = rsp_zero_q[1];
  assign bus.rsp1_err    = rsp_err_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M3 = 64'hFFFF_FFFF_FFFF_FFFD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [65:0] q0[$];
  logic [65:0] q1[$];

  alu_arbiter_if #(.WIDTH(64), .CTRL_W(4)) bus ();
  alu_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Shared alu; unsupported codes yield a junk value the arbiter must mask.
  always_comb begin
    case (bus.alu_ctrl)
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0111: bus.alu_result = bus.alu_b;
      4'b1100: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_result = 64'h0000_0000_DEAD_BEEF;
    endcase
    bus.alu_zero = (bus.alu_result == 64'd0);
  end

  function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    logic [63:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = b;
      4'b1100: r = ~(a | b);
      default: return {1'b1, 1'b1, 64'd0};
    endcase
    return {1'b0, (r == 64'd0), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check grants, push accepted ops, then pop on the produced response.
  task automatic cycle(input string tag,
                       input logic v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0, input logic rr0,
                       input logic v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1, input logic rr1,
                       input logic eg0, input logic eg1);
    logic p0, p1;
    logic [65:0] e;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0; bus.rsp0_ready = rr0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1; bus.rsp1_ready = rr1;
    #1;
    chk({tag, "_ready0"}, 64'(bus.req0_ready), 64'(eg0));
    chk({tag, "_ready1"}, 64'(bus.req1_ready), 64'(eg1));
    p0 = bus.req0_valid && bus.req0_ready;
    p1 = bus.req1_valid && bus.req1_ready;
    if (p0) q0.push_back(ref_op(a0, b0, c0));
    if (p1) q1.push_back(ref_op(a1, b1, c1));
    @(posedge clk);
    #1;
    if (p0) begin
      chk({tag, "_rsp0_valid"}, 64'(bus.rsp0_valid), 64'd1);
      if (q0.size() == 0) chk({tag, "_q0_empty"}, 64'd0, 64'd1);
      else begin
        e = q0.pop_front();
        chk({tag, "_rsp0_result"}, bus.rsp0_result, e[63:0]);
        chk({tag, "_rsp0_zero"}, 64'(bus.rsp0_zero), 64'(e[64]));
        chk({tag, "_rsp0_err"}, 64'(bus.rsp0_err), 64'(e[65]));
      end
    end else if (rr0) chk({tag, "_rsp0_drained"}, 64'(bus.rsp0_valid), 64'd0);
    if (p1) begin
      chk({tag, "_rsp1_valid"}, 64'(bus.rsp1_valid), 64'd1);
      if (q1.size() == 0) chk({tag, "_q1_empty"}, 64'd0, 64'd1);
      else begin
        e = q1.pop_front();
        chk({tag, "_rsp1_result"}, bus.rsp1_result, e[63:0]);
        chk({tag, "_rsp1_zero"}, 64'(bus.rsp1_zero), 64'(e[64]));
        chk({tag, "_rsp1_err"}, 64'(bus.rsp1_err), 64'(e[65]));
      end
    end else if (rr1) chk({tag, "_rsp1_drained"}, 64'(bus.rsp1_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] sweep_exp [6];
    logic [3:0]  sweep_op  [6];
    logic        sweep_z   [6];
    sweep_op = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    sweep_exp = '{64'd0, M1, M1, 64'd3, M2, 64'd0};
    sweep_z  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_ctrl = 0; bus.rsp0_ready = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_ctrl = 0; bus.rsp1_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    chk("rst_rsp0_result", bus.rsp0_result, 64'd0);
    chk("rst_rsp1_err", 64'(bus.rsp1_err), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_alu_a", bus.alu_a, 64'd0);
    chk("idle_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("idle_ready0", 64'(bus.req0_ready), 64'd0);

    // Both requesting every cycle: strict alternation starting at requester 0
    cycle("alt0", 1, 64'd1, M2, 4'b0110, 1, 1, 64'd1, 64'd1, 4'b0110, 1, 1, 0);
    chk("alt0_r0_is_3", bus.rsp0_result, 64'd3);
    cycle("alt1", 1, 64'd1, M2, 4'b0110, 1, 1, 64'd1, 64'd1, 4'b0110, 1, 0, 1);
    chk("alt1_r1_is_0", bus.rsp1_result, 64'd0);
    chk("alt1_z1", 64'(bus.rsp1_zero), 64'd1);
    cycle("alt2", 1, 64'd7, 64'd2, 4'b0010, 1, 1, 64'd5, 64'd9, 4'b0001, 1, 1, 0);
    cycle("alt3", 1, 64'd7, 64'd2, 4'b0010, 1, 1, 64'd5, 64'd9, 4'b0001, 1, 0, 1);

    // Requester 0 alone: -1 + -2
    cycle("solo0", 1, M1, M2, 4'b0010, 1, 0, 0, 0, 4'b0000, 1, 1, 0);
    chk("solo0_result", bus.rsp0_result, M3);
    chk("solo0_zero", 64'(bus.rsp0_zero), 64'd0);

    // Backpressure on requester 0 while requester 1 streams
    for (int i = 0; i < 3; i++) begin
      cycle("bp", 1, 64'd4, 64'd4, 4'b0110, 0, 1, 64'(i), 64'd1, 4'b0010, 1, 0, 1);
      chk("bp_hold_valid", 64'(bus.rsp0_valid), 64'd1);
      chk("bp_hold_result", bus.rsp0_result, M3);
      chk("bp_hold_zero", 64'(bus.rsp0_zero), 64'd0);
    end
    cycle("bp_release", 1, 64'd4, 64'd4, 4'b0110, 1, 1, 64'd8, 64'd1, 4'b0010, 1, 1, 0);
    chk("bp_release_zero", 64'(bus.rsp0_zero), 64'd1);

    // Unsupported code then a legal one on requester 1
    cycle("bad1", 0, 0, 0, 4'b0000, 1, 1, 64'd5, 64'd3, 4'b1010, 1, 0, 1);
    chk("bad1_err", 64'(bus.rsp1_err), 64'd1);
    chk("bad1_result", bus.rsp1_result, 64'd0);
    cycle("good1", 0, 0, 0, 4'b0000, 1, 1, 64'd2, 64'd3, 4'b0010, 1, 0, 1);
    chk("good1_err_clear", 64'(bus.rsp1_err), 64'd0);
    chk("good1_result", bus.rsp1_result, 64'd5);

    // Sweep all supported codes with a = 1, b = -2
    for (int i = 0; i < 6; i++) begin
      cycle("sweep", 1, 64'd1, M2, sweep_op[i], 1, 0, 0, 0, 4'b0000, 1, 1, 0);
      chk("sweep_const_result", bus.rsp0_result, sweep_exp[i]);
      chk("sweep_const_zero", 64'(bus.rsp0_zero), 64'(sweep_z[i]));
    end

    // Asynchronous reset while a response is held
    bus.req0_valid = 1'b1;
    bus.rsp0_ready = 1'b0;
    #2;
    chk("midop_pre_valid", 64'(bus.rsp0_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("midop_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    chk("midop_rsp0_result", bus.rsp0_result, 64'd0);
    chk("midop_ready0", 64'(bus.req0_ready), 64'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_no_rsp0", 64'(bus.rsp0_valid), 64'd0);
    chk("post_reset_no_rsp1", 64'(bus.rsp1_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
